// File: rtl/imt_apb_initiator_pkg.sv
// Shared definitions for the APB initiator slice.
//   APB_AW / APB_DW        : address and data widths of the APB side.
//   TIMEOUT_CYCLES_DEFAULT : default limit on ACCESS wait cycles; 0 disables it.
//   apb_state_e            : transfer FSM states.
package imt_apb_pkg;

  localparam int unsigned APB_AW                 = 32;
  localparam int unsigned APB_DW                 = 32;
  localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 255;
  localparam int unsigned WAIT_CNT_W             = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

endpackage

// File: rtl/imt_apb_initiator_if.sv
// Bundle of the command, response and APB signals around the initiator.
//   master : view of the initiator itself (drives cmd_ready, rsp_*, busy, APB requests).
//   slave  : view of the surrounding logic (command issuer plus APB completer).
interface imt_apb_initiator_if
  import imt_apb_pkg::*;
(
  input logic clk
);

  logic              cmd_valid;
  logic              cmd_ready;
  logic [APB_AW-1:0] cmd_addr;
  logic [APB_DW-1:0] cmd_wdata;
  logic              cmd_write;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [APB_DW-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;
  logic              busy;
  logic [APB_AW-1:0] PADDR;
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [APB_DW-1:0] PWDATA;
  logic [APB_DW-1:0] PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (
    input  clk,
    input  cmd_valid, cmd_addr, cmd_wdata, cmd_write, rsp_ready,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, busy,
    output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  clk,
    output cmd_valid, cmd_addr, cmd_wdata, cmd_write, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, busy,
    input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );

endinterface

// File: rtl/imt_apb_initiator.sv
// Single-transfer APB initiator: accepts one command, runs SETUP/ACCESS on
// APB, and presents the result on a valid/ready response port.
// Ports:
//   clk_in, reset_int       : clock, synchronous active-high reset
//   cmd_*                   : command request (valid/ready, addr, wdata, write)
//   rsp_*                   : response (valid/ready, rdata, err, timeout)
//   busy                    : FSM is not IDLE
//   PADDR..PSLVERR          : APB master signals
// TIMEOUT_CYCLES bounds the ACCESS cycles with PREADY=0 (0 = unbounded).
module imt_apb_initiator
  import imt_apb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic              clk_in,
  input  logic              reset_int,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [APB_AW-1:0] cmd_addr,
  input  logic [APB_DW-1:0] cmd_wdata,
  input  logic              cmd_write,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [APB_DW-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              busy,
  output logic [APB_AW-1:0] PADDR,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [APB_DW-1:0] PWDATA,
  input  logic [APB_DW-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  // The counter holds the number of wait cycles already seen, so the abort
  // fires in the ACCESS cycle where it equals TIMEOUT_CYCLES-1 with PREADY=0.
  localparam bit                     TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam int unsigned            TO_LIM  = TO_EN ? (TIMEOUT_CYCLES - 1) : 0;
  localparam logic [WAIT_CNT_W-1:0]  TO_LAST = WAIT_CNT_W'(TO_LIM);

  apb_state_e              state_q,       state_d;
  logic [APB_AW-1:0]       paddr_q,       paddr_d;
  logic [APB_DW-1:0]       pwdata_q,      pwdata_d;
  logic                    pwrite_q,      pwrite_d;
  logic [APB_DW-1:0]       rsp_rdata_q,   rsp_rdata_d;
  logic                    rsp_err_q,     rsp_err_d;
  logic                    rsp_timeout_q, rsp_timeout_d;
  logic [WAIT_CNT_W-1:0]   wait_cnt_q,    wait_cnt_d;

  always_ff @(posedge clk_in) begin
    if (reset_int) begin
      state_q       <= IDLE;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      pwrite_q      <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      wait_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      pwrite_q      <= pwrite_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
      wait_cnt_q    <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    pwrite_d      = pwrite_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    wait_cnt_d    = wait_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          paddr_d    = cmd_addr;
          pwdata_d   = cmd_wdata;
          pwrite_d   = cmd_write;
          wait_cnt_d = '0;
          state_d    = SETUP;
        end
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        // Completion is checked first so PREADY wins over a same-cycle timeout.
        if (PREADY) begin
          rsp_rdata_d   = pwrite_q ? '0 : PRDATA;
          rsp_err_d     = PSLVERR;
          rsp_timeout_d = 1'b0;
          state_d       = RESP;
        end else if (TO_EN && (wait_cnt_q == TO_LAST)) begin
          rsp_rdata_d   = '0;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          state_d       = RESP;
        end else if (wait_cnt_q != '1) begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign cmd_ready   = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign rsp_valid   = (state_q == RESP);
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;
  assign PSEL        = (state_q == SETUP) || (state_q == ACCESS);
  assign PENABLE     = (state_q == ACCESS);
  assign PADDR       = paddr_q;
  assign PWRITE      = pwrite_q;
  assign PWDATA      = pwdata_q;

endmodule

// File: tb/tb_imt_apb_initiator.sv
// Directed and randomized checks of imt_apb_initiator with TIMEOUT_CYCLES=4.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_imt_apb_initiator;
  import imt_apb_pkg::*;

  localparam int unsigned TB_TO = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  imt_apb_initiator_if bus (.clk(clk));

  imt_apb_initiator #(.TIMEOUT_CYCLES(TB_TO)) dut (
    .clk_in      (clk),
    .reset_int   (rst),
    .cmd_valid   (bus.cmd_valid),
    .cmd_ready   (bus.cmd_ready),
    .cmd_addr    (bus.cmd_addr),
    .cmd_wdata   (bus.cmd_wdata),
    .cmd_write   (bus.cmd_write),
    .rsp_valid   (bus.rsp_valid),
    .rsp_ready   (bus.rsp_ready),
    .rsp_rdata   (bus.rsp_rdata),
    .rsp_err     (bus.rsp_err),
    .rsp_timeout (bus.rsp_timeout),
    .busy        (bus.busy),
    .PADDR       (bus.PADDR),
    .PSEL        (bus.PSEL),
    .PENABLE     (bus.PENABLE),
    .PWRITE      (bus.PWRITE),
    .PWDATA      (bus.PWDATA),
    .PRDATA      (bus.PRDATA),
    .PREADY      (bus.PREADY),
    .PSLVERR     (bus.PSLVERR)
  );

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference: outcome of one transfer from the completer's wait count.
  task automatic model(input int unsigned waits, input logic w, input logic [31:0] rd,
                       input logic err, output int unsigned last_k,
                       output logic [31:0] e_rdata, output logic e_err, output logic e_to);
    e_to    = (TB_TO != 0) && (waits >= TB_TO);
    last_k  = e_to ? TB_TO - 1 : waits;
    e_rdata = (e_to || w) ? 32'h0 : rd;
    e_err   = e_to ? 1'b1 : err;
  endtask

  // Entered and left at a falling edge with the DUT in IDLE.
  task automatic run_xfer(input logic [31:0] a, input logic [31:0] wd, input logic w,
                          input int unsigned waits, input logic [31:0] rd, input logic err,
                          input logic glitch, input int unsigned hold);
    int unsigned last_k;
    logic [31:0] e_rdata;
    logic e_err, e_to;
    model(waits, w, rd, err, last_k, e_rdata, e_err, e_to);

    chk("idle_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("idle_busy", 32'(bus.busy), 32'd0);
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = a;
    bus.cmd_wdata = wd;
    bus.cmd_write = w;
    tick();
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = $urandom;
    bus.cmd_wdata = $urandom;
    chk("setup_psel", 32'(bus.PSEL), 32'd1);
    chk("setup_penable", 32'(bus.PENABLE), 32'd0);
    chk("setup_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    chk("setup_paddr", bus.PADDR, a);
    chk("setup_pwrite", 32'(bus.PWRITE), 32'(w));
    chk("setup_pwdata", bus.PWDATA, wd);
    tick();
    for (int unsigned k = 0; k <= last_k; k++) begin
      chk("access_psel", 32'(bus.PSEL), 32'd1);
      chk("access_penable", 32'(bus.PENABLE), 32'd1);
      chk("access_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("access_paddr", bus.PADDR, a);
      chk("access_pwrite", 32'(bus.PWRITE), 32'(w));
      chk("access_pwdata", bus.PWDATA, wd);
      bus.PREADY  = (k == waits);
      bus.PSLVERR = (k == waits) ? err : glitch;
      bus.PRDATA  = (k == waits) ? rd : $urandom;
      tick();
    end
    bus.PREADY  = 1'b0;
    bus.PSLVERR = 1'b0;
    bus.PRDATA  = $urandom;
    for (int unsigned h = 0; h <= hold; h++) begin
      chk("resp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("resp_rdata", bus.rsp_rdata, e_rdata);
      chk("resp_err", 32'(bus.rsp_err), 32'(e_err));
      chk("resp_timeout", 32'(bus.rsp_timeout), 32'(e_to));
      chk("resp_psel", 32'(bus.PSEL), 32'd0);
      chk("resp_penable", 32'(bus.PENABLE), 32'd0);
      chk("resp_cmd_ready", 32'(bus.cmd_ready), 32'd0);
      chk("resp_busy", 32'(bus.busy), 32'd1);
      if (h == hold) begin
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b1;
      end else begin
        bus.cmd_valid = 1'b1;
        bus.rsp_ready = 1'b0;
      end
      tick();
    end
    bus.rsp_ready = 1'b0;
    chk("post_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("post_psel", 32'(bus.PSEL), 32'd0);
    chk("post_paddr_held", bus.PADDR, a);
    chk("post_pwdata_held", bus.PWDATA, wd);
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.cmd_write = 1'b0;
    bus.rsp_ready = 1'b0;
    bus.PRDATA    = '0;
    bus.PREADY    = 1'b0;
    bus.PSLVERR   = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_psel", 32'(bus.PSEL), 32'd0);
    chk("rst_penable", 32'(bus.PENABLE), 32'd0);
    chk("rst_pwrite", 32'(bus.PWRITE), 32'd0);
    chk("rst_paddr", bus.PADDR, 32'd0);
    chk("rst_pwdata", bus.PWDATA, 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    chk("rst_rsp_timeout", 32'(bus.rsp_timeout), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    rst = 1'b0;
    tick();
    chk("rst_release_cmd_ready", 32'(bus.cmd_ready), 32'd1);

    // Zero-wait write
    run_xfer(32'h0000_0010, 32'hDEAD_BEEF, 1'b1, 0, 32'hA5A5_A5A5, 1'b0, 1'b0, 0);
    // Read with three wait cycles
    run_xfer(32'h0000_0004, 32'h0, 1'b0, 3, 32'h1234_5678, 1'b0, 1'b0, 0);
    // Slave error on completion
    run_xfer(32'h0000_0008, 32'h0, 1'b0, 0, 32'hCAFE_F00D, 1'b1, 1'b0, 0);
    // PSLVERR pulses while PREADY=0 are ignored
    run_xfer(32'h0000_000C, 32'h0, 1'b0, 2, 32'h0BAD_F00D, 1'b0, 1'b1, 0);
    // PREADY stuck low: timeout abort
    run_xfer(32'h0000_0020, 32'h0, 1'b0, 100, 32'h1111_2222, 1'b0, 1'b0, 0);
    // PREADY on the 4th ACCESS cycle: normal completion
    run_xfer(32'h0000_0024, 32'h0, 1'b0, 3, 32'h3333_4444, 1'b0, 1'b0, 0);
    // Response held off for 5 cycles, then back-to-back command
    run_xfer(32'h0000_0030, 32'h5555_6666, 1'b1, 1, 32'h0, 1'b0, 1'b0, 5);
    run_xfer(32'h0000_0034, 32'h0, 1'b0, 0, 32'h7777_8888, 1'b0, 1'b0, 0);

    // Reset during ACCESS
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = 32'h0000_0040;
    bus.cmd_write = 1'b0;
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    chk("pre_rst_penable", 32'(bus.PENABLE), 32'd1);
    rst = 1'b1;
    bus.PREADY = 1'b0;
    tick();
    chk("midrst_psel", 32'(bus.PSEL), 32'd0);
    chk("midrst_penable", 32'(bus.PENABLE), 32'd0);
    chk("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    rst = 1'b0;
    bus.PREADY = 1'b1;
    tick();
    chk("midrst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    bus.PREADY = 1'b0;
    for (int unsigned i = 0; i < 3; i++) begin
      tick();
      chk("midrst_no_rsp", 32'(bus.rsp_valid), 32'd0);
    end

    // Randomized transfers
    for (int unsigned i = 0; i < 24; i++) begin
      run_xfer($urandom, $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 6),
               $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               $urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
